fft_stage_sequencer: RTL and testbench
======================================

# fft_stage_sequencer

Folded-FFT controller that time-multiplexes one stage of datapath (front crossbar, butterfly array, back crossbar) across all log2(SIZE_FFT) stages of a transform. It accepts a full frame of SIZE_FFT complex samples, holds them in a frame buffer, and issues the buffer to the shared datapath once per stage with the stage index that configures the crossbars. It writes each stage result back into the buffer and presents the finished frame downstream. It sits between the frame source (deserializer) and the frame sink (serializer), and owns the only copy of in-flight data.

## Interface
- BIT_WIDTH, 32, width of each real/imaginary sample
- SIZE_FFT, 8, points per frame; power of two, >= 2
- BIT_REVERSE, 1, 1 = store input frame in bit-reversed index order; 0 = store in natural order
- Derived: N_STAGES = log2(SIZE_FFT); STAGE_W = max(1, ceil(log2(N_STAGES)))

Ports:
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high
- recv_real / recv_imaginary  in  BIT_WIDTH x SIZE_FFT  input frame
- recv_val  in  1  input frame valid
- recv_rdy  out  1  sequencer can accept a frame
- dp_send_real / dp_send_imaginary  out  BIT_WIDTH x SIZE_FFT  buffer contents to the datapath
- dp_send_val  out  1  stage operands valid
- dp_send_rdy  in  1  datapath accepts operands
- dp_stage  out  STAGE_W  stage index driving the STAGE_FFT select of both crossbars
- dp_recv_real / dp_recv_imaginary  in  BIT_WIDTH x SIZE_FFT  stage results
- dp_recv_val  in  1  results valid
- dp_recv_rdy  out  1  sequencer accepts results
- send_real / send_imaginary  out  BIT_WIDTH x SIZE_FFT  finished frame
- send_val  out  1  finished frame valid
- send_rdy  in  1  sink accepts frame

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Reset forces IDLE.
- IDLE: recv_rdy=1. On recv_val&&recv_rdy, the buffer captures the frame.
  - With BIT_REVERSE=1, lane i is written to buf[bitrev(i)]. With BIT_REVERSE=0, lane i is written to buf[i].
  - stage counter is set to 0; next state is ISSUE.
- ISSUE: dp_send_val=1; dp_send_* = buf; dp_stage = stage.
  - On dp_send_rdy, go to WAIT. Otherwise hold, with operands and dp_stage stable.
- WAIT: dp_recv_rdy=1; dp_stage holds the current stage.
  - On dp_recv_val, buf <= dp_recv_*.
  - If stage == N_STAGES-1, go to DONE. Otherwise increment stage and go to ISSUE.
- DONE: send_val=1; send_* = buf.
  - On send_rdy, go to IDLE. Otherwise hold with stable data.
- Exactly one handshake event counts per state. Handshakes on val/rdy lines outside their state are ignored:
  - dp_recv_val in ISSUE,
  - recv_val outside IDLE.
- No arithmetic on samples: the block only stores and forwards BIT_WIDTH-bit values unchanged.
- stage never exceeds N_STAGES-1 and never wraps.
- send_* and dp_send_* are driven from buf in all states. Only the val signals gate their meaning.

## Timing
- Reset values:
  - state=IDLE, stage=0, buf all zero;
  - recv_rdy=1 in the first cycle after reset deasserts;
  - dp_send_val=0, dp_recv_rdy=0, send_val=0;
  - dp_stage=0; send_*=0; dp_send_*=0.
- All outputs are registered-state decodes (Moore). No combinational path exists from any *_val/*_rdy input to any *_val/*_rdy output.
- The frame is accepted at edge T. With a datapath that is always ready and returns results with zero wait:
  - ISSUE for stage s occupies cycle T+1+2s;
  - WAIT for stage s occupies cycle T+2+2s;
  - send_val rises at cycle T+1+2*N_STAGES (T+7 for SIZE_FFT=8).
- Each cycle of dp_send_rdy=0 or dp_recv_val=0 adds exactly one cycle. Each cycle of send_rdy=0 in DONE adds one cycle before recv_rdy returns.
- recv_rdy=1 no earlier than the cycle after the send handshake. Throughput is at most one frame per 2+2*N_STAGES cycles.
- Reset asserted mid-operation, in any state, takes effect at that edge:
  - the in-flight frame is discarded;
  - outputs take their reset values next cycle;
  - a pending dp_recv_val is ignored.
- dp_recv_val arriving in the same cycle the state enters WAIT is accepted in that cycle.

## Test plan
- Reset, then idle:
  - stimulus: assert reset 2 cycles, then release.
  - required: recv_rdy=1, all vals 0, dp_stage=0, send_real[*]=0.
- Bit-reverse load, SIZE_FFT=8, BIT_REVERSE=1:
  - stimulus: input real lanes 0..7 = 0,1,...,7; the bench datapath is a pass-through.
  - required: dp_send_real in stage 0 = 0,4,2,6,1,5,3,7; final send_real identical.
- Stage sequencing:
  - stimulus: the datapath model adds (dp_stage+1) to every real lane; input all 0x10; BIT_REVERSE=0.
  - required: dp_stage = 0,1,2 across ISSUE phases; final send_real = 0x16 on all lanes; send_val at T+7.
- Backpressure:
  - stimulus: dp_send_rdy low 3 cycles in stage 1; dp_recv_val delayed 2 cycles in stage 2; send_rdy low 4 cycles.
  - required: operands and dp_stage stable while stalled; send_val at T+7+5; send_val held 4 extra cycles; recv_rdy=1 the cycle after send_rdy.
- Ignored strobes:
  - stimulus: pulse recv_val during WAIT; pulse dp_recv_val during ISSUE with garbage 0xDEAD.
  - required: no new frame captured; 0xDEAD never appears on send_real.
- Reset mid-frame:
  - stimulus: assert reset in WAIT of stage 1.
  - required: next cycle recv_rdy=1, dp_recv_rdy=0, send_val=0. A following frame completes normally with correct values.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: folded-FFT controller. Holds one frame in a buffer and
// replays it through a single shared stage datapath once per FFT stage,
// writing each stage result back, then hands the finished frame downstream.
//
// Handshake rule for all three channels (recv, dp_send/dp_recv, send): a
// transfer happens on a rising edge where valid and ready are both 1. Every
// valid/ready output is a pure decode of the registered state, so no input
// strobe ever reaches an output strobe combinationally. Strobes arriving in
// a state that does not own that channel are ignored.
module fft_stage_sequencer #(
   parameter int BIT_WIDTH   = 32,
   parameter int SIZE_FFT    = 8,
   parameter int BIT_REVERSE = 1,
   localparam int N_STAGES   = $clog2(SIZE_FFT),
   localparam int STAGE_W    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]  recv_real,
   input  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]  recv_imaginary,
   input  logic                                recv_val,
   output logic                                recv_rdy,
   output logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]  dp_send_real,
   output logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]  dp_send_imaginary,
   output logic                                dp_send_val,
   input  logic                                dp_send_rdy,
   output logic [STAGE_W-1:0]                  dp_stage,
   input  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]  dp_recv_real,
   input  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]  dp_recv_imaginary,
   input  logic                                dp_recv_val,
   output logic                                dp_recv_rdy,
   output logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]  send_real,
   output logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]  send_imaginary,
   output logic                                send_val,
   input  logic                                send_rdy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(N_STAGES - 1);

   // state_q is the observable FSM state for checkers bound to this block.
   state_t                              state_q, state_d;
   logic [STAGE_W-1:0]                  stage_q, stage_d;
   logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]  buf_re_q, buf_re_d;
   logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]  buf_im_q, buf_im_d;

   // Buffer slot for input lane 'lane': bit-reversed index when enabled, so
   // the first stage sees operands in decimation-in-time order.
   function automatic logic [N_STAGES-1:0] buf_index(input int lane);
      logic [N_STAGES-1:0] idx;
      logic [N_STAGES-1:0] rev;
      idx = N_STAGES'(lane);
      rev = '0;
      for (int b = 0; b < N_STAGES; b++) begin
         rev[N_STAGES-1-b] = idx[b];
      end
      return (BIT_REVERSE != 0) ? rev : idx;
   endfunction

   // State, stage counter and frame buffer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         stage_q  <= '0;
         buf_re_q <= '0;
         buf_im_q <= '0;
      end else begin
         state_q  <= state_d;
         stage_q  <= stage_d;
         buf_re_q <= buf_re_d;
         buf_im_q <= buf_im_d;
      end
   end

   // Next-state logic: one handshake per state, off-state strobes ignored.
   always_comb begin
      state_d  = state_q;
      stage_d  = stage_q;
      buf_re_d = buf_re_q;
      buf_im_d = buf_im_q;
      case (state_q)
         S_IDLE: begin
            if (recv_val) begin
               for (int i = 0; i < SIZE_FFT; i++) begin
                  buf_re_d[buf_index(i)] = recv_real[i];
                  buf_im_d[buf_index(i)] = recv_imaginary[i];
               end
               stage_d = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (dp_send_rdy) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (dp_recv_val) begin
               buf_re_d = dp_recv_real;
               buf_im_d = dp_recv_imaginary;
               if (stage_q == LAST_STAGE) begin
                  state_d = S_DONE;
               end else begin
                  stage_d = stage_q + 1'b1;
                  state_d = S_ISSUE;
               end
            end
         end
         S_DONE: begin
            if (send_rdy) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Moore output decode; data ports always mirror the buffer.
   always_comb begin
      recv_rdy          = (state_q == S_IDLE);
      dp_send_val       = (state_q == S_ISSUE);
      dp_recv_rdy       = (state_q == S_WAIT);
      send_val          = (state_q == S_DONE);
      dp_stage          = stage_q;
      dp_send_real      = buf_re_q;
      dp_send_imaginary = buf_im_q;
      send_real         = buf_re_q;
      send_imaginary    = buf_im_q;
   end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: table vectors for the directed cases, a
// randomized frame loop, and a hand-written mid-frame reset sequence. The
// expected frames come from a reference model of the whole transform flow.
module tb_fft_stage_sequencer;

  localparam int W   = 32;
  localparam int SZ  = 8;
  localparam int NST = 3;
  localparam int BR  = 1;

  typedef logic [SZ-1:0][W-1:0] frame_t;

  typedef struct {
    frame_t in_re;
    frame_t in_im;
    int     mode;
    logic [NST-1:0][7:0] ss;
    logic [NST-1:0][7:0] rs;
    int     os;
    bit     garb;
    frame_t exp_st0;
    frame_t exp_fin;
    int     exp_rel;
  } vec_t;

  // clock / reset
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  frame_t     recv_real, recv_imaginary, dp_recv_real, dp_recv_imaginary;
  frame_t     dp_send_real, dp_send_imaginary, send_real, send_imaginary;
  logic       recv_val, recv_rdy, dp_send_val, dp_send_rdy;
  logic       dp_recv_val, dp_recv_rdy, send_val, send_rdy;
  logic [1:0] dp_stage;

  fft_stage_sequencer #(.BIT_WIDTH(W), .SIZE_FFT(SZ), .BIT_REVERSE(BR)) dut (
    .clk(clk), .reset(reset),
    .recv_real(recv_real), .recv_imaginary(recv_imaginary),
    .recv_val(recv_val), .recv_rdy(recv_rdy),
    .dp_send_real(dp_send_real), .dp_send_imaginary(dp_send_imaginary),
    .dp_send_val(dp_send_val), .dp_send_rdy(dp_send_rdy),
    .dp_stage(dp_stage),
    .dp_recv_real(dp_recv_real), .dp_recv_imaginary(dp_recv_imaginary),
    .dp_recv_val(dp_recv_val), .dp_recv_rdy(dp_recv_rdy),
    .send_real(send_real), .send_imaginary(send_imaginary),
    .send_val(send_val), .send_rdy(send_rdy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // frame configuration and results
  frame_t      in_re, in_im;
  int          cur_mode;
  int          cfg_ss[NST];
  int          cfg_rs[NST];
  int          cfg_os;
  bit          cfg_garb;
  int          abort_stage;
  logic [W-1:0] k_add[NST];
  logic [W-1:0] k_xor[NST];
  frame_t      ref_re[NST+1];
  frame_t      ref_im[NST+1];
  frame_t      got_st0, got_fin;
  int          got_rel, got_hold;

  vec_t vecs[4];
  int   perm[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // the stage operation the bench datapath applies (and the model assumes)
  task automatic apply(input int md, input int s, input frame_t ire, input frame_t iim,
                       output frame_t ore, output frame_t oim);
    ore = ire;
    oim = iim;
    for (int j = 0; j < SZ; j++) begin
      if (md == 1) ore[j] = ire[j] + W'(s + 1);
      else if (md == 2) begin
        ore[j] = ire[j] + k_add[s];
        oim[j] = iim[j] ^ k_xor[s];
      end
    end
  endtask

  // reference: load permutation, then each stage applied in turn
  task automatic build_ref();
    frame_t r, m, nr, nm;
    int x, rv;
    for (int j = 0; j < SZ; j++) begin
      x = j;
      rv = 0;
      for (int b = 0; b < NST; b++) begin
        rv = rv * 2 + (x % 2);
        x = x / 2;
      end
      if (BR == 0) rv = j;
      r[rv] = in_re[j];
      m[rv] = in_im[j];
    end
    ref_re[0] = r;
    ref_im[0] = m;
    for (int s = 0; s < NST; s++) begin
      apply(cur_mode, s, r, m, nr, nm);
      r = nr;
      m = nm;
      ref_re[s+1] = r;
      ref_im[s+1] = m;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // drive one frame through the DUT, acting as source, datapath and sink
  task automatic do_frame();
    int s, ss, rs, os, rel, exp_rel, hold;
    bit first_done, finished, aborted;
    frame_t cap_re, cap_im, o_re, o_im, dead;
    for (int j = 0; j < SZ; j++) dead[j] = 32'hDEAD;
    build_ref();
    exp_rel = 1 + 2 * NST + cfg_os * 0;
    for (int k = 0; k < NST; k++) exp_rel += cfg_ss[k] + cfg_rs[k];
    chk("recv_rdy_idle", recv_rdy, 1);
    recv_real = in_re;
    recv_imaginary = in_im;
    recv_val = 1'b1;
    step();
    recv_val = 1'b0;
    rel = 1;
    s = 0;
    ss = cfg_ss[0];
    rs = cfg_rs[0];
    os = cfg_os;
    hold = 0;
    first_done = 1'b1;
    finished = 1'b0;
    aborted = 1'b0;
    cap_re = '0;
    cap_im = '0;
    for (int cyc = 0; cyc < 100 && !finished && !aborted; cyc++) begin
      dp_send_rdy = 1'b0;
      dp_recv_val = 1'b0;
      send_rdy = 1'b0;
      recv_val = 1'b0;
      chk("recv_rdy_busy", recv_rdy, 0);
      chk("one_phase", 2'(dp_send_val) + 2'(dp_recv_rdy) + 2'(send_val), 1);
      if (abort_stage == s && dp_recv_rdy) begin
        reset = 1'b1;
        dp_recv_val = 1'b1;
        dp_recv_real = dead;
        dp_recv_imaginary = dead;
        step();
        reset = 1'b0;
        dp_recv_val = 1'b0;
        chk("rst_recv_rdy", recv_rdy, 1);
        chk("rst_dp_recv_rdy", dp_recv_rdy, 0);
        chk("rst_send_val", send_val, 0);
        chk("rst_dp_send_val", dp_send_val, 0);
        chk("rst_dp_stage", dp_stage, 0);
        chk("rst_send_real", send_real, 0);
        aborted = 1'b1;
      end else begin
        if (dp_send_val) begin
          chk("issue_stage", dp_stage, s);
          chk("issue_re", dp_send_real, ref_re[s]);
          chk("issue_im", dp_send_imaginary, ref_im[s]);
          if (s == 0) got_st0 = dp_send_real;
          if (cfg_garb) begin
            dp_recv_val = 1'b1;
            dp_recv_real = dead;
            dp_recv_imaginary = dead;
          end
          if (ss > 0) ss--;
          else begin
            dp_send_rdy = 1'b1;
            cap_re = dp_send_real;
            cap_im = dp_send_imaginary;
          end
        end else if (dp_recv_rdy) begin
          chk("wait_stage", dp_stage, s);
          if (cfg_garb) begin
            recv_val = 1'b1;
            recv_real = ~in_re;
            recv_imaginary = ~in_im;
          end
          if (rs > 0) begin
            rs--;
            dp_recv_real = dead;
            dp_recv_imaginary = dead;
          end else begin
            apply(cur_mode, s, cap_re, cap_im, o_re, o_im);
            dp_recv_real = o_re;
            dp_recv_imaginary = o_im;
            dp_recv_val = 1'b1;
            s++;
            if (s < NST) begin
              ss = cfg_ss[s];
              rs = cfg_rs[s];
            end
          end
        end else if (send_val) begin
          if (first_done) begin
            got_rel = rel;
            chk("send_latency", rel, exp_rel);
            first_done = 1'b0;
          end
          chk("done_re", send_real, ref_re[NST]);
          chk("done_im", send_imaginary, ref_im[NST]);
          got_fin = send_real;
          hold++;
          if (os > 0) os--;
          else send_rdy = 1'b1;
        end
        step();
        rel++;
        if (send_rdy) begin
          send_rdy = 1'b0;
          chk("recv_rdy_after_send", recv_rdy, 1);
          chk("send_val_dropped", send_val, 0);
          chk("send_hold", hold, cfg_os + 1);
          got_hold = hold;
          finished = 1'b1;
        end
      end
    end
    dp_send_rdy = 1'b0;
    dp_recv_val = 1'b0;
    recv_val = 1'b0;
    if (!finished && !aborted) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout: frame did not complete within 100 cycles");
      do_reset();
    end
  endtask

  task automatic load_vec(input vec_t v);
    in_re = v.in_re;
    in_im = v.in_im;
    cur_mode = v.mode;
    for (int k = 0; k < NST; k++) begin
      cfg_ss[k] = int'(v.ss[k]);
      cfg_rs[k] = int'(v.rs[k]);
    end
    cfg_os = v.os;
    cfg_garb = v.garb;
    abort_stage = -1;
  endtask

  initial begin
    reset = 1'b1;
    recv_val = 1'b0;
    dp_send_rdy = 1'b0;
    dp_recv_val = 1'b0;
    send_rdy = 1'b0;
    recv_real = '0;
    recv_imaginary = '0;
    dp_recv_real = '0;
    dp_recv_imaginary = '0;
    for (int k = 0; k < NST; k++) begin
      k_add[k] = '0;
      k_xor[k] = '0;
    end

    // vector table
    for (int v = 0; v < 4; v++) begin
      vecs[v].ss = '0;
      vecs[v].rs = '0;
      vecs[v].os = 0;
      vecs[v].garb = 1'b0;
      vecs[v].in_im = '0;
      vecs[v].exp_rel = 7;
    end
    for (int j = 0; j < SZ; j++) begin
      vecs[0].in_re[j] = W'(j);
      vecs[0].in_im[j] = W'(100 + j);
      vecs[0].exp_st0[j] = W'(perm[j]);
      vecs[0].exp_fin[j] = W'(perm[j]);
      vecs[1].in_re[j] = 32'h10;
      vecs[1].exp_st0[j] = 32'h10;
      vecs[1].exp_fin[j] = 32'h16;
      vecs[2].in_re[j] = W'(j);
      vecs[2].exp_st0[j] = W'(perm[j]);
      vecs[2].exp_fin[j] = W'(perm[j] + 6);
      vecs[3].in_re[j] = W'(32'h20 + j);
      vecs[3].in_im[j] = W'(j);
      vecs[3].exp_st0[j] = W'(32'h20 + perm[j]);
      vecs[3].exp_fin[j] = W'(32'h20 + perm[j]);
    end
    vecs[0].mode = 0;
    vecs[1].mode = 1;
    vecs[2].mode = 1;
    vecs[2].ss[1] = 8'd3;
    vecs[2].rs[2] = 8'd2;
    vecs[2].os = 4;
    vecs[2].exp_rel = 12;
    vecs[3].mode = 0;
    vecs[3].garb = 1'b1;

    // reset then idle
    step();
    step();
    reset = 1'b0;
    chk("reset_recv_rdy", recv_rdy, 1);
    chk("reset_dp_send_val", dp_send_val, 0);
    chk("reset_dp_recv_rdy", dp_recv_rdy, 0);
    chk("reset_send_val", send_val, 0);
    chk("reset_dp_stage", dp_stage, 0);
    chk("reset_send_real", send_real, 0);
    chk("reset_send_imag", send_imaginary, 0);
    chk("reset_dp_send_real", dp_send_real, 0);
    step();

    // directed table vectors
    for (int v = 0; v < 4; v++) begin
      load_vec(vecs[v]);
      do_frame();
      chk("tbl_stage0", got_st0, vecs[v].exp_st0);
      chk("tbl_final", got_fin, vecs[v].exp_fin);
      chk("tbl_latency", got_rel, vecs[v].exp_rel);
      for (int j = 0; j < SZ; j++) chk("no_dead", got_fin[j] == 32'hDEAD, 0);
      step();
    end

    // randomized frames against the reference model
    for (int f = 0; f < 24; f++) begin
      for (int j = 0; j < SZ; j++) begin
        in_re[j] = $urandom;
        in_im[j] = $urandom;
      end
      for (int k = 0; k < NST; k++) begin
        k_add[k] = $urandom;
        k_xor[k] = $urandom;
        cfg_ss[k] = $urandom_range(0, 2);
        cfg_rs[k] = $urandom_range(0, 2);
      end
      cur_mode = 2;
      cfg_os = $urandom_range(0, 3);
      cfg_garb = 1'($urandom_range(0, 1));
      abort_stage = -1;
      do_frame();
      if ($urandom_range(0, 1) == 1) step();
    end

    // reset in WAIT of stage 1, then a clean frame
    for (int j = 0; j < SZ; j++) begin
      in_re[j] = W'(3 * j + 1);
      in_im[j] = W'(50 - j);
    end
    cur_mode = 1;
    for (int k = 0; k < NST; k++) begin
      cfg_ss[k] = 0;
      cfg_rs[k] = 0;
    end
    cfg_os = 0;
    cfg_garb = 1'b0;
    abort_stage = 1;
    do_frame();
    abort_stage = -1;
    do_frame();
    for (int j = 0; j < SZ; j++) chk("after_rst_final", got_fin[j], W'(3 * perm[j] + 1 + 6));
    chk("after_rst_latency", got_rel, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
